// File: rtl/accel_decimator.sv
// accel_decimator: averages 2^LOG2_N sign-magnitude X/Y/Z accel samples
// and emits one decimated sign-magnitude triple with a 1-cycle valid.
// Ports: clk, RST (sync, active-high), in_valid, x_raw/y_raw/z_raw [9:0];
//   out_valid, x_avg/y_avg/z_avg [9:0] (held), sample_cnt [LOG2_N-1:0],
//   sensor_stall (level, high from idle timeout until next sample).
module accel_decimator #(
  parameter int LOG2_N      = 3,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [9:0]        x_raw,
  input  logic [9:0]        y_raw,
  input  logic [9:0]        z_raw,
  output logic              out_valid,
  output logic [9:0]        x_avg,
  output logic [9:0]        y_avg,
  output logic [9:0]        z_avg,
  output logic [LOG2_N-1:0] sample_cnt,
  output logic              sensor_stall
);

  localparam int W  = 10 + LOG2_N;
  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  typedef logic signed [W-1:0] acc_t;

  typedef enum logic {
    ACC,
    STALL
  } state_t;

  // Sign-magnitude to two's complement; 10'h200 maps to 0 naturally.
  function automatic acc_t to_tc(input logic [9:0] raw);
    acc_t m;
    m = acc_t'({{(W-9){1'b0}}, raw[8:0]});
    return raw[9] ? -m : m;
  endfunction

  // Divide magnitude (truncates toward zero), suppress negative zero.
  function automatic logic [9:0] to_sm(input acc_t sum);
    acc_t       a;
    logic [8:0] mag;
    a   = sum[W-1] ? -sum : sum;
    mag = 9'(a >> LOG2_N);
    return {sum[W-1] && (mag != 9'd0), mag};
  endfunction

  state_t            state_q, state_d;
  acc_t              acc_x_q, acc_y_q, acc_z_q;
  acc_t              acc_x_d, acc_y_d, acc_z_d;
  acc_t              sum_x, sum_y, sum_z;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [9:0]        avg_x_q, avg_y_q, avg_z_q;
  logic [9:0]        avg_x_d, avg_y_d, avg_z_d;
  logic              vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    acc_z_d = acc_z_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    avg_x_d = avg_x_q;
    avg_y_d = avg_y_q;
    avg_z_d = avg_z_q;
    vld_d   = 1'b0;

    sum_x = acc_x_q + to_tc(x_raw);
    sum_y = acc_y_q + to_tc(y_raw);
    sum_z = acc_z_q + to_tc(z_raw);

    if (in_valid) begin
      // Any accepted sample ends a stall; the stall already
      // cleared the accumulators, so this is sample 1.
      state_d = ACC;
      idle_d  = '0;
      if (cnt_q == '1) begin
        avg_x_d = to_sm(sum_x);
        avg_y_d = to_sm(sum_y);
        avg_z_d = to_sm(sum_z);
        vld_d   = 1'b1;
        acc_x_d = '0;
        acc_y_d = '0;
        acc_z_d = '0;
        cnt_d   = '0;
      end else begin
        acc_x_d = sum_x;
        acc_y_d = sum_y;
        acc_z_d = sum_z;
        cnt_d   = cnt_q + 1'b1;
      end
    end else begin
      if (idle_q != IW'(TIMEOUT_CYC))
        idle_d = idle_q + 1'b1;
      if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
        state_d = STALL;
        acc_x_d = '0;
        acc_y_d = '0;
        acc_z_d = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= ACC;
      acc_x_q <= '0;
      acc_y_q <= '0;
      acc_z_q <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      avg_x_q <= '0;
      avg_y_q <= '0;
      avg_z_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      acc_z_q <= acc_z_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      avg_x_q <= avg_x_d;
      avg_y_q <= avg_y_d;
      avg_z_q <= avg_z_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid    = vld_q;
  assign x_avg        = avg_x_q;
  assign y_avg        = avg_y_q;
  assign z_avg        = avg_z_q;
  assign sample_cnt   = cnt_q;
  assign sensor_stall = (state_q == STALL);

endmodule

// File: tb/tb_accel_decimator.sv
// tb_accel_decimator: directed bench for accel_decimator
// (LOG2_N=3, TIMEOUT_CYC=1023) with immediate-assertion checks.
module tb_accel_decimator;

  logic       clk = 1'b0;
  logic       RST;
  logic       in_valid;
  logic [9:0] x_raw, y_raw, z_raw;
  logic       out_valid;
  logic [9:0] x_avg, y_avg, z_avg;
  logic [2:0] sample_cnt;
  logic       sensor_stall;

  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;
  int p0;

  always #5 clk = ~clk;

  accel_decimator #(.LOG2_N(3), .TIMEOUT_CYC(1023)) dut (
    .clk(clk),
    .RST(RST),
    .in_valid(in_valid),
    .x_raw(x_raw),
    .y_raw(y_raw),
    .z_raw(z_raw),
    .out_valid(out_valid),
    .x_avg(x_avg),
    .y_avg(y_avg),
    .z_avg(z_avg),
    .sample_cnt(sample_cnt),
    .sensor_stall(sensor_stall)
  );

  always @(negedge clk)
    if (out_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] x, input logic [9:0] y,
                      input logic [9:0] z);
    in_valid = 1'b1;
    x_raw = x;
    y_raw = y;
    z_raw = z;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    x_raw = '0;
    y_raw = '0;
    z_raw = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_avg(input string tag, input logic [9:0] ex,
                         input logic [9:0] ey, input logic [9:0] ez);
    chk({tag, "_x"}, x_avg, ex);
    chk({tag, "_y"}, y_avg, ey);
    chk({tag, "_z"}, z_avg, ez);
  endtask

  initial begin
    RST = 1'b1;
    in_valid = 1'b0;
    x_raw = '0;
    y_raw = '0;
    z_raw = '0;

    // 1: reset and idle
    tick();
    tick();
    RST = 1'b0;
    chk("rst_vld", out_valid, 0);
    chk_avg("rst", 10'h000, 10'h000, 10'h000);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_stall", sensor_stall, 0);
    idle(20);
    chk("idle_pulses", pulses, 0);
    chk("idle_stall", sensor_stall, 0);
    chk("idle_cnt", sample_cnt, 0);

    // 2: constant window, then back-to-back second window
    for (int i = 0; i < 7; i++) send(10'h064, 10'h000, 10'h1FF);
    chk("w1_cnt7", sample_cnt, 7);
    chk("w1_pre_vld", out_valid, 0);
    send(10'h064, 10'h000, 10'h1FF);
    chk("w1_vld", out_valid, 1);
    chk_avg("w1", 10'h064, 10'h000, 10'h1FF);
    chk("w1_cnt0", sample_cnt, 0);
    send(10'h064, 10'h000, 10'h1FF);
    chk("w2_first_vld", out_valid, 0);
    chk("w2_cnt1", sample_cnt, 1);
    for (int i = 0; i < 6; i++) send(10'h064, 10'h000, 10'h1FF);
    chk("w2_pre_vld", out_valid, 0);
    send(10'h064, 10'h000, 10'h1FF);
    chk("w2_vld", out_valid, 1);
    idle(1);
    chk("w2_vld_drop", out_valid, 0);
    chk("w2_pulses", pulses, 2);
    chk_avg("w2_hold", 10'h064, 10'h000, 10'h1FF);

    // 3: mixed-sign truncation and negative zero
    idle(3);
    for (int i = 0; i < 8; i++)
      send(i < 4 ? 10'h014 : 10'h20A,
           i < 4 ? 10'h214 : 10'h00A,
           i == 0 ? 10'h203 : 10'h200);
    chk("mix_vld", out_valid, 1);
    chk_avg("mix", 10'h005, 10'h205, 10'h000);

    // 4: full-scale negative, then cancelling extremes
    for (int i = 0; i < 8; i++) send(10'h3FF, 10'h3FF, 10'h3FF);
    chk("neg_vld", out_valid, 1);
    chk_avg("neg", 10'h3FF, 10'h3FF, 10'h3FF);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(10'h1FF, 10'h1FF, 10'h1FF);
      else send(10'h3FF, 10'h3FF, 10'h3FF);
    end
    chk("alt_vld", out_valid, 1);
    chk_avg("alt", 10'h000, 10'h000, 10'h000);

    // 5: timeout discards a partial window
    for (int i = 0; i < 3; i++) send(10'h050, 10'h050, 10'h050);
    chk("to_cnt3", sample_cnt, 3);
    p0 = pulses;
    idle(1022);
    chk("to_1022_stall", sensor_stall, 0);
    chk("to_1022_cnt", sample_cnt, 3);
    idle(1);
    chk("to_stall", sensor_stall, 1);
    chk("to_cnt0", sample_cnt, 0);
    idle(5);
    chk("to_stall_hold", sensor_stall, 1);
    chk("to_no_pulse", pulses, p0);
    chk("to_hold_avg", x_avg, 10'h000);
    send(10'h008, 10'h008, 10'h008);
    chk("to_clear", sensor_stall, 0);
    chk("to_fresh_cnt", sample_cnt, 1);
    for (int i = 0; i < 7; i++) send(10'h008, 10'h008, 10'h008);
    chk("to_vld", out_valid, 1);
    chk_avg("to", 10'h008, 10'h008, 10'h008);

    // 6: reset mid-window with a concurrent sample
    idle(2);
    for (int i = 0; i < 5; i++) send(10'h0C8, 10'h0C8, 10'h0C8);
    chk("mr_cnt5", sample_cnt, 5);
    RST = 1'b1;
    send(10'h0C8, 10'h0C8, 10'h0C8);
    RST = 1'b0;
    chk("mr_cnt0", sample_cnt, 0);
    chk("mr_vld", out_valid, 0);
    chk("mr_avg0", x_avg, 10'h000);
    p0 = pulses;
    for (int i = 0; i < 8; i++) send(10'h010, 10'h010, 10'h010);
    chk("mr_final_vld", out_valid, 1);
    chk_avg("mr", 10'h010, 10'h010, 10'h010);
    idle(2);
    chk("mr_one_pulse", pulses - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
